// File: rtl/usb_buf_pkg.sv
// Shared constants and read-size encoding for the USB receive byte buffer.
// Latency: none (declarations only).
// Backpressure: n/a.
package usb_buf_pkg;

    localparam int BUF_DEPTH = 64;
    localparam int PTR_W     = 6;
    localparam int OCC_W     = 7;

    typedef enum logic [1:0] {
        GET_BYTE = 2'd0,
        GET_HALF = 2'd1,
        GET_WORD = 2'd2
    } get_size_t;

    // Number of bytes a host access asks for; the reserved encoding reads a word.
    function automatic logic [2:0] req_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            GET_BYTE: n = 3'd1;
            GET_HALF: n = 3'd2;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/usb_buf_mem.sv
// DEPTH x 8 register array: one write port, four combinational read ports at rd_ptr+0..3.
// Latency: write lands on the next rising edge; reads are combinational.
// Backpressure: none; the caller only asserts wr_en for accepted writes.
// Ports: clk, wr_en/wr_ptr/wr_dat (write), rd_ptr (base read address), rd_dat (4 bytes, lane i = rd_ptr+i).
module usb_buf_mem
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_ptr,
    input  logic [7:0]      wr_dat,
    input  logic [AW-1:0]   rd_ptr,
    output logic [3:0][7:0] rd_dat
);

    // Contents are deliberately not reset; occupancy decides what is valid.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Address arithmetic wraps modulo DEPTH because DEPTH is a power of 2.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_dat[i] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Byte FIFO between the USB receiver and the host-side slave; 1/2/4-byte little-endian reads.
// Latency: a read request sampled on one edge updates rx_data/rx_data_valid on that same edge (1 cycle).
// Backpressure: writes at full are dropped; short reads return the bytes available, zero-padded.
// Ports: clk, n_rst (sync, active-low); store_rx_packet_data/rx_packet_data (write), flush,
//        get_rx_data/get_size (read), rx_data/rx_data_valid (read result),
//        buffer_occupancy/buffer_full/buffer_empty (status).
// Build option USB_BUF_ERR_FLAGS_EN adds sticky overflow_err/underflow_err outputs.
module usb_rx_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          store_rx_packet_data,
    input  logic [7:0]    rx_packet_data,
    input  logic          flush,
    input  logic          get_rx_data,
    input  logic [1:0]    get_size,
`ifdef USB_BUF_ERR_FLAGS_EN
    output logic          overflow_err,
    output logic          underflow_err,
`endif
    output logic [31:0]   rx_data,
    output logic          rx_data_valid,
    output logic [CW-1:0] buffer_occupancy,
    output logic          buffer_full,
    output logic          buffer_empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [3:0][7:0] rd_dat;

    logic [2:0]      req_n;
    logic [2:0]      take;
    logic [2:0]      take_eff;
    logic            wr_ok;
    logic [31:0]     rx_nxt;
    logic [CW-1:0]   occ_nxt;

    assign buffer_full  = (buffer_occupancy == DEPTH_C);
    assign buffer_empty = (buffer_occupancy == '0);

    always_comb begin
        req_n = req_bytes(get_size);
        // When fewer bytes are held than requested, occupancy is < 4 so its low bits are exact.
        take  = (buffer_occupancy < CW'(req_n)) ? buffer_occupancy[2:0] : req_n;
        take_eff = get_rx_data ? take : 3'd0;
        // Accept decision uses pre-cycle occupancy: a same-cycle read never frees room.
        wr_ok = store_rx_packet_data && (buffer_occupancy != DEPTH_C);
        for (int i = 0; i < 4; i++) begin
            rx_nxt[8*i +: 8] = (3'(i) < take) ? rd_dat[i] : 8'h00;
        end
        occ_nxt = buffer_occupancy + CW'(wr_ok) - CW'(take_eff);
    end

    usb_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_ok && !flush),
        .wr_ptr (wr_ptr),
        .wr_dat (rx_packet_data),
        .rd_ptr (rd_ptr),
        .rd_dat (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            buffer_occupancy <= '0;
            rx_data          <= '0;
            rx_data_valid    <= 1'b0;
        end else if (flush) begin
            // rx_data keeps its last value; only the pulse and bookkeeping are cleared.
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            buffer_occupancy <= '0;
            rx_data_valid    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr           <= rd_ptr + AW'(take_eff);
            buffer_occupancy <= occ_nxt;
            rx_data_valid    <= get_rx_data;
            if (get_rx_data) begin
                rx_data <= rx_nxt;
            end
        end
    end

`ifdef USB_BUF_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (store_rx_packet_data && !wr_ok) begin
                overflow_err <= 1'b1;
            end
            if (get_rx_data && (take < req_n)) begin
                underflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Self-checking bench for usb_rx_data_buffer: queue-based reference plus literal spot checks.
// Latency: inputs driven on falling edges; outputs compared on the following falling edge.
// Backpressure: exercised via full-buffer writes and short reads.
module tb_usb_rx_data_buffer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        store_rx_packet_data = 1'b0;
    logic [7:0]  rx_packet_data = 8'h00;
    logic        flush = 1'b0;
    logic        get_rx_data = 1'b0;
    logic [1:0]  get_size = 2'd0;
    logic [31:0] rx_data;
    logic        rx_data_valid;
    logic [6:0]  buffer_occupancy;
    logic        buffer_full;
    logic        buffer_empty;
`ifdef USB_BUF_ERR_FLAGS_EN
    logic        overflow_err;
    logic        underflow_err;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    usb_rx_data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .flush                (flush),
        .get_rx_data          (get_rx_data),
        .get_size             (get_size),
`ifdef USB_BUF_ERR_FLAGS_EN
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err),
`endif
        .rx_data              (rx_data),
        .rx_data_valid        (rx_data_valid),
        .buffer_occupancy     (buffer_occupancy),
        .buffer_full          (buffer_full),
        .buffer_empty         (buffer_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue, updated on each rising edge from the sampled inputs.
    byte unsigned q[$];
    logic [31:0]  m_data = '0;
    logic         m_vld  = 1'b0;
    logic         m_ovf  = 1'b0;
    logic         m_unf  = 1'b0;

    always @(posedge clk) begin
        int pre, n, k;
        logic [31:0] d;
        if (!n_rst) begin
            q.delete();
            m_data = '0;
            m_vld = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_vld = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pre = q.size();
            n = (get_size == 2'd0) ? 1 : (get_size == 2'd1) ? 2 : 4;
            if (get_rx_data) begin
                k = (n < pre) ? n : pre;
                d = '0;
                for (int i = 0; i < k; i++) d[8*i +: 8] = q.pop_front();
                m_data = d;
                m_vld = 1'b1;
                if (k < n) m_unf = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            if (store_rx_packet_data) begin
                if (pre < 64) q.push_back(rx_packet_data);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("occupancy", 32'(buffer_occupancy), 32'(q.size()));
            chk("rx_data", rx_data, m_data);
            chk("rx_data_valid", 32'(rx_data_valid), 32'(m_vld));
            chk("buffer_full", 32'(buffer_full), 32'(q.size() == 64));
            chk("buffer_empty", 32'(buffer_empty), 32'(q.size() == 0));
`ifdef USB_BUF_ERR_FLAGS_EN
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("underflow_err", 32'(underflow_err), 32'(m_unf));
`endif
        end
    end

    // One cycle: inputs applied now, results visible when this returns (next falling edge).
    task automatic cyc(input bit st, input logic [7:0] b, input bit gt, input logic [1:0] sz,
                       input bit fl, input bit rst_n);
        store_rx_packet_data = st;
        rx_packet_data       = b;
        get_rx_data          = gt;
        get_size             = sz;
        flush                = fl;
        n_rst                = rst_n;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [1:0] sz);
        cyc(1'b0, 8'h00, 1'b1, sz, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic do_flush();
        cyc(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1);
    endtask

    initial begin
        // Reset
        cyc(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("reset rx_data", rx_data, 32'h0);
        chk("reset occupancy", 32'(buffer_occupancy), 32'd0);
        chk("reset empty", 32'(buffer_empty), 32'd1);

        // 1) four bytes, one word read
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        chk("t1 occ before", 32'(buffer_occupancy), 32'd4);
        rd(2'd2);
        chk("t1 word", rx_data, 32'h44332211);
        chk("t1 valid", 32'(rx_data_valid), 32'd1);
        chk("t1 occ after", 32'(buffer_occupancy), 32'd0);
        idle();
        chk("t1 valid drop", 32'(rx_data_valid), 32'd0);
        chk("t1 hold", rx_data, 32'h44332211);

        // 3) short read
        wr(8'hA1); wr(8'hB2); wr(8'hC3);
        rd(2'd2);
        chk("t3 short word", rx_data, 32'h00C3B2A1);
        chk("t3 empty", 32'(buffer_empty), 32'd1);
`ifdef USB_BUF_ERR_FLAGS_EN
        chk("t3 underflow", 32'(underflow_err), 32'd1);
`endif
        rd(2'd0);
        chk("empty read data", rx_data, 32'h0);
        chk("empty read valid", 32'(rx_data_valid), 32'd1);

        // 4) simultaneous write and read at occupancy 10
        do_flush();
        for (int i = 0; i < 10; i++) wr(8'(8'h50 + i));
        cyc(1'b1, 8'hEE, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("t4 oldest", rx_data, 32'h00000050);
        chk("t4 occ", 32'(buffer_occupancy), 32'd10);
        rd(2'd0);
        chk("t4 next oldest", rx_data, 32'h00000051);

        // 2) fill to 64, then an extra write is dropped; a read at full does not admit a write
        do_flush();
        for (int i = 0; i < 64; i++) wr(8'(i));
        chk("t2 occ", 32'(buffer_occupancy), 32'd64);
        chk("t2 full", 32'(buffer_full), 32'd1);
        wr(8'hFF);
        chk("t2 occ after drop", 32'(buffer_occupancy), 32'd64);
`ifdef USB_BUF_ERR_FLAGS_EN
        chk("t2 overflow", 32'(overflow_err), 32'd1);
`endif
        cyc(1'b1, 8'hFE, 1'b1, 2'd2, 1'b0, 1'b1);
        chk("t2 read at full", rx_data, 32'h03020100);
        chk("t2 occ read at full", 32'(buffer_occupancy), 32'd60);

        // 6) flush beats same-cycle store and get
        do_flush();
        wr(8'h01); wr(8'h02); wr(8'h03);
        rd(2'd2);
        for (int i = 0; i < 20; i++) wr(8'(8'h20 + i));
        chk("t6 occ", 32'(buffer_occupancy), 32'd20);
        cyc(1'b1, 8'h99, 1'b1, 2'd2, 1'b1, 1'b1);
        chk("t6 occ flushed", 32'(buffer_occupancy), 32'd0);
        chk("t6 no valid", 32'(rx_data_valid), 32'd0);
`ifdef USB_BUF_ERR_FLAGS_EN
        chk("t6 underflow cleared", 32'(underflow_err), 32'd0);
        chk("t6 overflow cleared", 32'(overflow_err), 32'd0);
`endif

        // 5) pointer wrap
        for (int i = 0; i < 60; i++) wr(8'(i));
        for (int i = 0; i < 60; i++) rd(2'd0);
        chk("t5 last single", rx_data, 32'h0000003B);
        for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
        rd(2'd2);
        chk("t5 word across wrap a", rx_data, 32'h83828180);
        rd(2'd3);
        chk("t5 word across wrap b", rx_data, 32'h87868584);
        chk("t5 occ", 32'(buffer_occupancy), 32'd0);

        // Reset mid-burst
        wr(8'h10); wr(8'h11);
        cyc(1'b1, 8'h12, 1'b1, 2'd2, 1'b0, 1'b0);
        chk("rst rx_data", rx_data, 32'h0);
        chk("rst valid", 32'(rx_data_valid), 32'd0);
        chk("rst occ", 32'(buffer_occupancy), 32'd0);
        idle();
        idle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
